// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
//
// Parametrised UART transmitter with an internal TX FIFO. Monitoring logic
// pushes words into the FIFO. The transmitter drains the FIFO one frame at a
// time onto txd. Consecutive frames run back to back with no idle gap between
// them.
//
// Frame format on txd (idle high, LSB first):
//   start(0) | DATA_BITS data | optional parity | STOP_BITS stop(1)
// Each bit lasts DIV = (CLK_FREQ + BAUD/2) / BAUD clock cycles (DIV >= 2).
//
// Handshake (write side): a write is accepted on a rising clk edge when
// wr_en=1 and full=0. A write while full=1 is dropped without side effects.
// The full flag is derived from the registered count only, so a pop in the
// same cycle does not open a slot for a write while full.
//
// Optional feature (macro UART_TX_CTS_EN): adds input cts_n (active low).
// It passes through a 2-flop synchroniser. A new frame starts only while the
// synchronised cts_n is 0. A frame that is already in flight always
// completes.
//
// Parameters:
//   CLK_FREQ   system clock frequency in Hz
//   BAUD       line rate in baud
//   DATA_BITS  data bits per frame, 5..9
//   PARITY     0 = none, 1 = even, 2 = odd
//   STOP_BITS  1 or 2
//   FIFO_DEPTH FIFO entries, power of 2, >= 2
//
// Ports:
//   clk         system clock
//   resetn      asynchronous active-low reset; aborts any frame, empties FIFO
//   wr_en       write strobe
//   wr_data     word to queue (DATA_BITS wide)
//   full        FIFO holds FIFO_DEPTH entries
//   fifo_count  entries queued, excluding the frame in flight
//   busy        frame in flight or FIFO not empty
//   txd         registered serial output, idle high
//   cts_n       (UART_TX_CTS_EN only) clear-to-send, active low, asynchronous
// -----------------------------------------------------------------------------
module uart_tx_fifo #(
    parameter int CLK_FREQ   = 10000000,
    parameter int BAUD       = 115200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                              clk,
    input  logic                              resetn,
    input  logic                              wr_en,
    input  logic [DATA_BITS-1:0]              wr_data,
    output logic                              full,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count,
    output logic                              busy,
`ifdef UART_TX_CTS_EN
    input  logic                              cts_n,
`endif
    output logic                              txd
);

    localparam int DIV   = (CLK_FREQ + BAUD / 2) / BAUD;
    localparam int DIV_W = $clog2(DIV);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int BIT_W = $clog2(DATA_BITS);

    localparam logic [DIV_W-1:0] BAUD_LOAD = DIV_W'(DIV - 1);
    localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_BITS - 1);
    localparam logic             LAST_STOP = 1'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PAR,
        STOP
    } state_t;

    // -------------------------------------------------------------------------
    // TX FIFO
    // -------------------------------------------------------------------------
    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wrPtr;
    logic [PTR_W-1:0]     rdPtr;
    logic [CNT_W-1:0]     count;
    logic                 push;
    logic                 pop;
    logic [DATA_BITS-1:0] headData;

    assign full       = (count == CNT_W'(FIFO_DEPTH));
    assign push       = wr_en & ~full;
    assign headData   = mem[rdPtr];
    assign fifo_count = count;

    // Storage has no reset: an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wrPtr] <= wr_data;
        end
    end

    // Pointers wrap naturally because FIFO_DEPTH is a power of two.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wrPtr <= wrPtr + PTR_W'(1);
            end
            if (pop) begin
                rdPtr <= rdPtr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Clear-to-send gating
    // -------------------------------------------------------------------------
    logic canStart;

`ifdef UART_TX_CTS_EN
    logic ctsMeta;
    logic ctsSync;

    // Reset to "not clear" so that nothing is sent until the PC side has
    // been observed asserting cts_n for two cycles.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ctsMeta <= 1'b1;
            ctsSync <= 1'b1;
        end else begin
            ctsMeta <= cts_n;
            ctsSync <= ctsMeta;
        end
    end

    assign canStart = ~ctsSync;
`else
    assign canStart = 1'b1;
`endif

    // -------------------------------------------------------------------------
    // Transmit FSM
    // -------------------------------------------------------------------------
    state_t               state;
    state_t               stateNext;
    logic [DIV_W-1:0]     baudCnt;
    logic [DIV_W-1:0]     baudCntNext;
    logic [BIT_W-1:0]     bitIdx;
    logic [BIT_W-1:0]     bitIdxNext;
    logic [DATA_BITS-1:0] shiftReg;
    logic [DATA_BITS-1:0] shiftNext;
    logic                 parityBit;
    logic                 parityNext;
    logic                 stopIdx;
    logic                 stopIdxNext;
    logic                 txdReg;
    logic                 txdNext;
    logic                 tick;
    logic                 startFrame;
    logic                 launch;

    // The counter only runs while a frame is in flight. A tick marks the last
    // cycle of the current bit.
    assign tick       = (baudCnt == '0);
    assign startFrame = (count != '0) && canStart;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            baudCnt   <= '0;
            bitIdx    <= '0;
            shiftReg  <= '0;
            parityBit <= 1'b0;
            stopIdx   <= 1'b0;
            txdReg    <= 1'b1;
        end else begin
            state     <= stateNext;
            baudCnt   <= baudCntNext;
            bitIdx    <= bitIdxNext;
            shiftReg  <= shiftNext;
            parityBit <= parityNext;
            stopIdx   <= stopIdxNext;
            txdReg    <= txdNext;
        end
    end

    always_comb begin
        stateNext   = state;
        baudCntNext = baudCnt;
        bitIdxNext  = bitIdx;
        shiftNext   = shiftReg;
        parityNext  = parityBit;
        stopIdxNext = stopIdx;
        txdNext     = txdReg;
        launch      = 1'b0;
        pop         = 1'b0;

        if (state != IDLE) begin
            baudCntNext = tick ? BAUD_LOAD : baudCnt - DIV_W'(1);
        end

        case (state)
            IDLE: begin
                txdNext = 1'b1;
                if (startFrame) begin
                    launch = 1'b1;
                end
            end

            START: begin
                if (tick) begin
                    stateNext  = DATA;
                    txdNext    = shiftReg[0];
                    bitIdxNext = '0;
                end
            end

            DATA: begin
                if (tick) begin
                    if (bitIdx == LAST_BIT) begin
                        stopIdxNext = 1'b0;
                        if (PARITY != 0) begin
                            stateNext = PAR;
                            txdNext   = parityBit;
                        end else begin
                            stateNext = STOP;
                            txdNext   = 1'b1;
                        end
                    end else begin
                        shiftNext  = shiftReg >> 1;
                        bitIdxNext = bitIdx + BIT_W'(1);
                        txdNext    = shiftReg[1];
                    end
                end
            end

            PAR: begin
                if (tick) begin
                    stateNext   = STOP;
                    txdNext     = 1'b1;
                    stopIdxNext = 1'b0;
                end
            end

            STOP: begin
                if (tick) begin
                    if (stopIdx == LAST_STOP) begin
                        if (startFrame) begin
                            // Chain straight into the next start bit.
                            launch = 1'b1;
                        end else begin
                            stateNext   = IDLE;
                            txdNext     = 1'b1;
                            baudCntNext = '0;
                        end
                    end else begin
                        stopIdxNext = stopIdx + 1'b1;
                    end
                end
            end

            default: begin
                stateNext   = IDLE;
                txdNext     = 1'b1;
                baudCntNext = '0;
            end
        endcase

        // Common frame launch: pop the head, latch its parity and drive
        // the start bit.
        if (launch) begin
            pop         = 1'b1;
            stateNext   = START;
            shiftNext   = headData;
            parityNext  = (PARITY == 2) ? ~(^headData) : (^headData);
            baudCntNext = BAUD_LOAD;
            txdNext     = 1'b0;
        end
    end

    assign txd  = txdReg;
    assign busy = (state != IDLE) || (count != '0);

endmodule

// File: tb/tb_uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_fifo
//
// Directed bench for uart_tx_fifo. Four instances share one clock and reset:
//   0: 8N1          1: 8E1          2: 8O1          3: 7N2
// All use DIV = 10 and a 16-entry FIFO. Inputs are driven and outputs are
// sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_uart_tx_fifo;

    localparam int DIV = 10;

    logic       clk    = 1'b0;
    logic       resetn = 1'b0;
    logic [3:0] wrEnV  = '0;
    logic [7:0] wrDataV [4];

    wire  [3:0] txdV;
    wire  [3:0] busyV;
    wire  [3:0] fullV;
    wire  [4:0] cntV [4];

    int         testsRun    = 0;
    int         testsFailed = 0;
    logic [7:0] expQ [$];

    always #5 clk = ~clk;

    uart_tx_fifo #(.CLK_FREQ(10000000), .BAUD(1000000), .DATA_BITS(8),
                   .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(16)) dut8n1 (
        .clk(clk), .resetn(resetn), .wr_en(wrEnV[0]), .wr_data(wrDataV[0]),
        .full(fullV[0]), .fifo_count(cntV[0]), .busy(busyV[0]),
`ifdef UART_TX_CTS_EN
        .cts_n(1'b0),
`endif
        .txd(txdV[0]));

    uart_tx_fifo #(.CLK_FREQ(10000000), .BAUD(1000000), .DATA_BITS(8),
                   .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(16)) dut8e1 (
        .clk(clk), .resetn(resetn), .wr_en(wrEnV[1]), .wr_data(wrDataV[1]),
        .full(fullV[1]), .fifo_count(cntV[1]), .busy(busyV[1]),
`ifdef UART_TX_CTS_EN
        .cts_n(1'b0),
`endif
        .txd(txdV[1]));

    uart_tx_fifo #(.CLK_FREQ(10000000), .BAUD(1000000), .DATA_BITS(8),
                   .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(16)) dut8o1 (
        .clk(clk), .resetn(resetn), .wr_en(wrEnV[2]), .wr_data(wrDataV[2]),
        .full(fullV[2]), .fifo_count(cntV[2]), .busy(busyV[2]),
`ifdef UART_TX_CTS_EN
        .cts_n(1'b0),
`endif
        .txd(txdV[2]));

    uart_tx_fifo #(.CLK_FREQ(10000000), .BAUD(1000000), .DATA_BITS(7),
                   .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(16)) dut7n2 (
        .clk(clk), .resetn(resetn), .wr_en(wrEnV[3]), .wr_data(wrDataV[3][6:0]),
        .full(fullV[3]), .fifo_count(cntV[3]), .busy(busyV[3]),
`ifdef UART_TX_CTS_EN
        .cts_n(1'b0),
`endif
        .txd(txdV[3]));

    task automatic checkEq(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp);
        testsRun++;
        if (obs !== exp) begin
            testsFailed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Expected line level at cycle c of a frame, from the frame format.
    function automatic logic expBit(input logic [7:0] data, input int nData,
                                    input int par, input int c);
        int   idx = c / DIV;
        logic p   = 1'b0;
        for (int j = 0; j < nData; j++) p ^= data[j];
        if (idx == 0) return 1'b0;
        if (idx <= nData) return data[idx-1];
        if (par != 0 && idx == nData + 1) return (par == 2) ? ~p : p;
        return 1'b1;
    endfunction

    task automatic writeByte(input int sel, input logic [7:0] data);
        wrEnV[sel]   = 1'b1;
        wrDataV[sel] = data;
        @(negedge clk);
        wrEnV[sel]   = 1'b0;
    endtask

    // Checks one frame cycle by cycle from cycle c0. With c0 = 0 it first
    // waits for the start bit and, when expWait >= 0, checks the wait length.
    task automatic checkFrame(input string tag, input int sel,
                              input logic [7:0] data, input int nData,
                              input int par, input int nStop, input int c0,
                              input int expWait);
        int waitCnt = 0;
        int errs    = 0;
        int len     = (1 + nData + ((par != 0) ? 1 : 0) + nStop) * DIV;
        if (c0 == 0) begin
            while (txdV[sel] !== 1'b0 && waitCnt < 1000) begin
                @(negedge clk);
                waitCnt++;
            end
            if (txdV[sel] !== 1'b0) begin
                checkEq({tag, "_start"}, 32'(txdV[sel]), 32'd0);
                return;
            end
            if (expWait >= 0) checkEq({tag, "_wait"}, waitCnt, expWait);
        end
        for (int c = c0; c < len; c++) begin
            if (txdV[sel] !== expBit(data, nData, par, c)) errs++;
            if (busyV[sel] !== 1'b1) errs++;
            @(negedge clk);
        end
        checkEq({tag, "_wave"}, errs, 0);
    endtask

    initial begin
        int errs;
        int expCount;
        logic [7:0] b;
        for (int i = 0; i < 4; i++) wrDataV[i] = '0;

        // Reset state of every instance.
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            checkEq($sformatf("rst_txd%0d", i), 32'(txdV[i]), 32'd1);
            checkEq($sformatf("rst_busy%0d", i), 32'(busyV[i]), 32'd0);
            checkEq($sformatf("rst_full%0d", i), 32'(fullV[i]), 32'd0);
            checkEq($sformatf("rst_cnt%0d", i), 32'(cntV[i]), 32'd0);
        end
        resetn = 1'b1;
        repeat (4) @(negedge clk);

        // 8N1 single byte 0x55: no bypass, one-cycle pop latency, 100-cycle frame.
        writeByte(0, 8'h55);
        checkEq("t1_cnt", 32'(cntV[0]), 32'd1);
        checkEq("t1_nobypass", 32'(txdV[0]), 32'd1);
        checkEq("t1_busy", 32'(busyV[0]), 32'd1);
        checkFrame("t1", 0, 8'h55, 8, 0, 1, 0, 1);
        checkEq("t1_busy_end", 32'(busyV[0]), 32'd0);
        checkEq("t1_txd_end", 32'(txdV[0]), 32'd1);

        // Even and odd parity frames (110 cycles each).
        writeByte(1, 8'h07);
        checkFrame("t2_even07", 1, 8'h07, 8, 1, 1, 0, 1);
        checkEq("t2_even_busy_end", 32'(busyV[1]), 32'd0);
        writeByte(2, 8'h07);
        checkFrame("t2_odd07", 2, 8'h07, 8, 2, 1, 0, 1);
        writeByte(2, 8'h00);
        checkFrame("t2_odd00", 2, 8'h00, 8, 2, 1, 0, 1);
        checkEq("t2_odd_busy_end", 32'(busyV[2]), 32'd0);

        // Burst of 18 writes: first pops at once, FIFO fills to 16, 0x11 dropped.
        for (int i = 0; i < 18; i++) begin
            wrEnV[0]   = 1'b1;
            wrDataV[0] = i[7:0];
            @(negedge clk);
            expCount = (i == 0) ? 1 : ((i > 16) ? 16 : i);
            checkEq($sformatf("t3_cnt%0d", i), 32'(cntV[0]), expCount);
            checkEq($sformatf("t3_full%0d", i), 32'(fullV[0]),
                    (expCount == 16) ? 32'd1 : 32'd0);
            if (i <= 16) expQ.push_back(i[7:0]);
            if (i == 0) checkEq("t3_nobypass", 32'(txdV[0]), 32'd1);
            if (i == 1) checkEq("t3_start", 32'(txdV[0]), 32'd0);
        end
        wrEnV[0] = 1'b0;
        b = expQ.pop_front();
        checkFrame($sformatf("t3_frame%0h", b), 0, b, 8, 0, 1, 16, -1);
        while (expQ.size() > 0) begin
            b = expQ.pop_front();
            checkFrame($sformatf("t3_frame%0h", b), 0, b, 8, 0, 1, 0, 0);
        end
        checkEq("t3_busy_end", 32'(busyV[0]), 32'd0);
        checkEq("t3_cnt_end", 32'(cntV[0]), 32'd0);
        errs = 0;
        repeat (200) begin
            if (txdV[0] !== 1'b1) errs++;
            @(negedge clk);
        end
        checkEq("t3_no_extra", errs, 0);

        // 7N2: 0x7F then 0x00 back to back, 20-cycle stop between.
        writeByte(3, 8'h7F);
        writeByte(3, 8'h00);
        checkFrame("t4_7f", 3, 8'h7F, 7, 0, 2, 0, 0);
        checkFrame("t4_00", 3, 8'h00, 7, 0, 2, 0, 0);
        checkEq("t4_busy_end", 32'(busyV[3]), 32'd0);

        // Reset during data bit 3 with 5 words queued.
        for (int i = 0; i < 6; i++) begin
            wrEnV[0]   = 1'b1;
            wrDataV[0] = 8'hC0 + i[7:0];
            @(negedge clk);
        end
        wrEnV[0] = 1'b0;
        checkEq("t5_cnt_pre", 32'(cntV[0]), 32'd5);
        repeat (41) @(negedge clk);
        checkEq("t5_txd_bit3", 32'(txdV[0]), 32'd0);
        resetn = 1'b0;
        #1;
        checkEq("t5_txd", 32'(txdV[0]), 32'd1);
        checkEq("t5_busy", 32'(busyV[0]), 32'd0);
        checkEq("t5_cnt", 32'(cntV[0]), 32'd0);
        checkEq("t5_full", 32'(fullV[0]), 32'd0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        errs = 0;
        repeat (300) begin
            if (txdV[0] !== 1'b1 || busyV[0] !== 1'b0) errs++;
            @(negedge clk);
        end
        checkEq("t5_quiet", errs, 0);
        writeByte(0, 8'hA3);
        checkFrame("t5_after", 0, 8'hA3, 8, 0, 1, 0, 1);
        checkEq("t5_busy_end", 32'(busyV[0]), 32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Parametrised UART transmitter that succeeds the fixed 8N2 diagnostic transmitter. It adds configurable data width, parity, stop bits and an integer baud divider, plus an internal TX FIFO so that monitoring logic can push bursts of bytes without waiting on the serial line. It sits between the housekeeping/diagnostic data path and the RS-232 pin to the ground PC.

Parameters:
CLK_FREQ, 10000000, system clock frequency in Hz
BAUD, 115200, line rate in baud; bit period DIV = (CLK_FREQ + BAUD/2)/BAUD clock cycles, DIV >= 2 required
DATA_BITS, 8, data bits per frame, legal range 5..9
PARITY, 0, 0 = none, 1 = even, 2 = odd
STOP_BITS, 1, stop bits per frame, 1 or 2
FIFO_DEPTH, 16, TX FIFO entries, power of 2, >= 2

Ports:
clk  in  1  system clock
resetn  in  1  asynchronous, active-low reset
wr_en  in  1  write strobe; accepted when wr_en=1 and full=0
wr_data  in  DATA_BITS  byte to queue, sampled on an accepted write
full  out  1  FIFO holds FIFO_DEPTH entries
fifo_count  out  $clog2(FIFO_DEPTH+1)  entries queued, excluding the frame in flight
busy  out  1  frame in flight OR fifo_count != 0
txd  out  1  serial output, idle high, registered

Behaviour:
- Reset, asynchronous, resetn=0: txd=1, busy=0, full=0, fifo_count=0, FSM=IDLE, baud counter=0, FIFO pointers cleared. Reset mid-frame aborts the frame and drops all queued data; txd returns high immediately.
- FIFO writes:
  - A write is accepted on a clk edge when wr_en=1 and full=0.
  - A write with full=1 is dropped silently; no state changes.
  - full is computed from the registered count. When the FIFO is full, a write in the same cycle as a pop is still rejected.
  - There is no bypass: a byte written into an empty FIFO is popped no earlier than the following edge.
- FSM states: IDLE, START, DATA, PAR, STOP.
  - IDLE: if fifo_count != 0, pop the head into the shift register, load the baud counter with DIV-1, set txd<=0, and go to START.
  - The baud counter decrements each cycle. A tick occurs when it reaches 0, after which it reloads DIV-1. Every bit lasts exactly DIV cycles.
  - START, on tick: go to DATA; txd<=shift[0] (LSB first); bit index=0.
  - DATA, on tick: shift right and increment the bit index. After DATA_BITS bits, go to PAR if PARITY!=0 (txd<=parity), else go to STOP (txd<=1).
  - PAR, on tick: go to STOP; txd<=1.
  - Parity is computed over the frame's data bits. Even: parity = XOR of the data bits. Odd: parity = inverted XOR.
  - STOP: lasts STOP_BITS*DIV cycles. On the final tick:
    - If the FIFO is non-empty (and the CTS condition is met when that feature is enabled): pop, txd<=0, enter START directly, with no idle gap between frames.
    - Otherwise: go to IDLE with txd=1.
- Frame length: (1 + DATA_BITS + (PARITY!=0) + STOP_BITS)*DIV cycles.
- Latency: a write accepted on edge k into an empty, idle block pops on edge k+1, and txd goes low from edge k+1.

Optional Feature:
UART_TX_CTS_EN: adds input port cts_n (1 bit, active low, synchronised internally by a 2-flop synchroniser).
- With the macro: a frame starts (from IDLE, or back-to-back from STOP) only when the synchronised cts_n=0. A frame already in flight always completes. While cts_n=1 the FIFO holds its data and busy stays high if data is queued.
- Without the macro: no cts_n port; frames start whenever data is queued.

Test Plan:
- Defaults with CLK_FREQ=10000000, BAUD=1000000 (DIV=10), 8N1. Write 0x55 -> txd low 10 cycles, then 1,0,1,0,1,0,1,0 at 10 cycles each, then high 10 cycles. Frame is 100 cycles; busy falls at cycle 101 after the pop.
- PARITY=1, then PARITY=2, DIV=10. Write 0x07 -> parity bit 1 (even). Write 0x07 with odd parity -> parity bit 0. Write 0x00 with odd parity -> parity bit 1. Frame is 110 cycles.
- FIFO_DEPTH=16, from idle. Drive wr_en for 18 consecutive cycles with data 0x00..0x11 -> the first byte is popped, fifo_count reaches 16 and full=1, 0x11 is dropped. Exactly 17 frames 0x00..0x10 are emitted back-to-back, with no high gap beyond the stop bit.
- STOP_BITS=2, DATA_BITS=7. Write 0x7F then 0x00 -> stop level held 20 cycles between frames. Each frame is 100 cycles.
- Reset mid-frame: assert resetn=0 during data bit 3 of a frame with 5 bytes queued -> txd=1, busy=0, fifo_count=0 immediately. After release, no frame is emitted until a new write.
- UART_TX_CTS_EN: hold cts_n=1 and write 3 bytes -> txd stays 1, fifo_count=3. Drop cts_n -> the first start bit begins 3 cycles later (2 synchroniser cycles + pop). Raise cts_n mid-frame 2 -> frame 2 completes and frame 3 is held.
